// File: rtl/display_value_sequencer.sv
// Serial double-dabble BCD sequencer for a 4-digit seven-segment display.
// Commits digits atomically with overflow marking, zero blanking and hold time.
module display_value_sequencer #(
   parameter int WIDTH       = 16,
   parameter int HOLD_CYCLES = 25_000_000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             val_valid,
   input  logic [WIDTH-1:0] val_data,
   output logic             val_ready,
   output logic [3:0]       dig0,
   output logic [3:0]       dig1,
   output logic [3:0]       dig2,
   output logic [3:0]       dig3,
   output logic             upd,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      CONV,
      COMMIT
   } state_t;

   localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(9999);
   localparam logic [3:0] D_ERR   = 4'hA;
   localparam logic [3:0] D_BLANK = 4'hB;
   localparam logic [3:0] D_DASH  = 4'hC;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] val;
   logic [15:0]      bcd;
   logic [15:0]      bcd_adj;
   logic [CW-1:0]    cnt;
   logic [HW-1:0]    hold;
   logic             ovf;
   logic             ovf_in;
   logic             accept;
   logic             last;
   logic             b3;
   logic             b2;
   logic             b1;

   assign val_ready = (state == IDLE) && (hold == '0) && !clr;
   assign busy      = (state != IDLE);
   assign accept    = val_valid && val_ready;
   assign ovf_in    = (val > MAX_VAL);
   assign last      = (cnt == CW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:   if (accept) state_n = CHECK;
         CHECK:  state_n = ovf_in ? COMMIT : CONV;
         CONV:   if (last) state_n = COMMIT;
         COMMIT: state_n = IDLE;
      endcase
      if (clr) state_n = IDLE;
   end

   // add-3 correction on every nibble before the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // blanking ripples down from the most significant digit
   always_comb begin
      b3 = BLANK_LZ && !ovf && (bcd[15:12] == 4'd0);
      b2 = b3 && (bcd[11:8] == 4'd0);
      b1 = b2 && (bcd[7:4] == 4'd0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val  <= '0;
         bcd  <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
         hold <= '0;
         upd  <= 1'b0;
         dig0 <= D_DASH;
         dig1 <= D_DASH;
         dig2 <= D_DASH;
         dig3 <= D_DASH;
      end else begin
         upd <= 1'b0;
         if (clr) begin
            hold <= '0;
            dig0 <= D_DASH;
            dig1 <= D_DASH;
            dig2 <= D_DASH;
            dig3 <= D_DASH;
         end else begin
            unique case (state)
               IDLE: begin
                  if (hold != '0) hold <= hold - HW'(1);
                  if (accept) val <= val_data;
               end
               CHECK: begin
                  ovf <= ovf_in;
                  cnt <= CW'(WIDTH);
                  if (ovf_in) bcd <= {D_ERR, D_DASH, D_DASH, D_DASH};
                  else        bcd <= '0;
               end
               CONV: begin
                  bcd <= {bcd_adj[14:0], val[WIDTH-1]};
                  val <= {val[WIDTH-2:0], 1'b0};
                  cnt <= cnt - CW'(1);
               end
               COMMIT: begin
                  dig3 <= b3 ? D_BLANK : bcd[15:12];
                  dig2 <= b2 ? D_BLANK : bcd[11:8];
                  dig1 <= b1 ? D_BLANK : bcd[7:4];
                  dig0 <= bcd[3:0];
                  upd  <= 1'b1;
                  hold <= HOLD_INIT;
               end
            endcase
         end
      end
   end

endmodule
